// File: rtl/rv_decode_pkg.sv
// Shared decode definitions for the IF/ID stage and the immediate sign-extend unit.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Encodings are consumed directly by the sign-extend unit's select input.
  typedef enum logic [2:0] {
    IMM_NONE  = 3'b000,
    IMM_U     = 3'b001,
    IMM_I     = 3'b010,
    IMM_SHAMT = 3'b011,
    IMM_B     = 3'b100,
    IMM_S     = 3'b101,
    IMM_J     = 3'b110
  } imm_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    imm_sel_e   imm_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } dec_t;

  // Decode of the NOP held in the output register after reset.
  localparam dec_t DEC_RESET = '{imm_sel: IMM_I, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, illegal: 1'b0};

endpackage

// File: rtl/imm_sel_decoder.sv
// Combinational first-level decode: immediate format, register specifiers, illegal flag.
module imm_sel_decoder
  import rv_decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  imm_sel_e   w_sel;
  logic       w_illegal;
  logic       w_rd_zero;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  // Every legal opcode ends in 2'b11, so compressed/garbage encodings fall to default.
  always_comb begin
    w_sel     = IMM_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: w_sel = IMM_U;
      OPC_LOAD, OPC_JALR: w_sel = IMM_I;
      OPC_OP_IMM: begin
        if (w_funct3 == 3'b001) begin
          if (w_funct7 == 7'b0000000) w_sel = IMM_SHAMT;
          else w_illegal = 1'b1;
        end else if (w_funct3 == 3'b101) begin
          if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) w_sel = IMM_SHAMT;
          else w_illegal = 1'b1;
        end else begin
          w_sel = IMM_I;
        end
      end
      OPC_BRANCH: w_sel = IMM_B;
      OPC_STORE:  w_sel = IMM_S;
      OPC_JAL:    w_sel = IMM_J;
      OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: w_sel = IMM_NONE;
      default:    w_illegal = 1'b1;
    endcase
  end

  assign w_rd_zero = w_illegal || (w_opcode == OPC_BRANCH) || (w_opcode == OPC_STORE);

  assign o_dec.imm_sel = w_sel;
  assign o_dec.rs1     = i_instr[19:15];
  assign o_dec.rs2     = i_instr[24:20];
  assign o_dec.rd      = w_rd_zero ? 5'd0 : i_instr[11:7];
  assign o_dec.illegal = w_illegal;

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with first-level decode on the input side.
// Optional one-entry skid buffer behind the output register when ID_SKID_EN is defined.
module if_id_decode
  import rv_decode_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [2:0]      out_imm_sel,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  // Handshake: a pair moves on an edge where valid && ready are both high on that side;
  // valid never depends on ready, and a raised out_valid holds its payload until taken.
  dec_t            w_in_dec;
  logic            w_in_xfer;
  logic            w_out_load;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [31:0]     r_out_instr;
  dec_t            r_out_dec;

  imm_sel_decoder u_imm_sel_decoder (
    .i_instr (in_instr),
    .o_dec   (w_in_dec)
  );

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_load = !r_out_valid || out_ready;

`ifdef ID_SKID_EN
  logic            r_skid_valid;
  logic            r_in_ready;
  logic [XLEN-1:0] r_skid_pc;
  logic [31:0]     r_skid_instr;
  dec_t            r_skid_dec;

  // r_in_ready mirrors !skid_valid as a flop; rst/flush gating keeps out_ready off this path.
  assign in_ready = r_in_ready && !rst && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_pc     <= RESET_PC;
      r_out_instr  <= NOP_INSTR;
      r_out_dec    <= DEC_RESET;
      r_skid_pc    <= RESET_PC;
      r_skid_instr <= NOP_INSTR;
      r_skid_dec   <= DEC_RESET;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_pc     <= r_skid_pc;
        r_out_instr  <= r_skid_instr;
        r_out_dec    <= r_skid_dec;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_xfer) begin
        r_out_pc     <= in_pc;
        r_out_instr  <= in_instr;
        r_out_dec    <= w_in_dec;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid_pc    <= in_pc;
      r_skid_instr <= in_instr;
      r_skid_dec   <= w_in_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end
`else
  assign in_ready = !rst && !flush && w_out_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= RESET_PC;
      r_out_instr <= NOP_INSTR;
      r_out_dec   <= DEC_RESET;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_out_pc    <= in_pc;
      r_out_instr <= in_instr;
      r_out_dec   <= w_in_dec;
      r_out_valid <= 1'b1;
    end else if (w_out_load) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign out_imm_sel = r_out_dec.imm_sel;
  assign out_rs1     = r_out_dec.rs1;
  assign out_rs2     = r_out_dec.rs2;
  assign out_rd      = r_out_dec.rd;
  assign out_illegal = r_out_dec.illegal;

endmodule

// File: tb/tb_if_id_decode.sv
// Directed bench for if_id_decode: reset, decode stream, illegal cases, stall, flush, mid-stream reset.
`timescale 1ns/1ps
module tb_if_id_decode;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef ID_SKID_EN
  localparam int EXP_STALL_ACC = 1;
`else
  localparam int EXP_STALL_ACC = 0;
`endif

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [XLEN-1:0] in_pc, out_pc;
  logic [31:0]     in_instr, out_instr;
  logic [2:0]      out_imm_sel;
  logic [4:0]      out_rs1, out_rs2, out_rd;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;
  vec_t vecs[13];

  logic [83:0] got, exp;

  if_id_decode #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_imm_sel(out_imm_sel), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_vecs();
    vecs[0]  = '{32'h123450B7, 3'b001, 5'd8, 5'd3, 5'd1, 1'b0}; // LUI
    vecs[1]  = '{32'h00500093, 3'b010, 5'd0, 5'd5, 5'd1, 1'b0}; // ADDI
    vecs[2]  = '{32'h00209113, 3'b011, 5'd1, 5'd2, 5'd2, 1'b0}; // SLLI
    vecs[3]  = '{32'h00208463, 3'b100, 5'd1, 5'd2, 5'd0, 1'b0}; // BEQ
    vecs[4]  = '{32'h0020A023, 3'b101, 5'd1, 5'd2, 5'd0, 1'b0}; // SW
    vecs[5]  = '{32'h008000EF, 3'b110, 5'd0, 5'd8, 5'd1, 1'b0}; // JAL
    vecs[6]  = '{32'h0000007F, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1}; // bad opcode
    vecs[7]  = '{32'h00000000, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1}; // all zero
    vecs[8]  = '{32'h40209113, 3'b000, 5'd1, 5'd2, 5'd0, 1'b1}; // SLLI funct7=0100000
    vecs[9]  = '{32'h4020D113, 3'b011, 5'd1, 5'd2, 5'd2, 1'b0}; // SRAI legal
    vecs[10] = '{32'h002081B3, 3'b000, 5'd1, 5'd2, 5'd3, 1'b0}; // ADD
    vecs[11] = '{32'h0220D113, 3'b000, 5'd1, 5'd2, 5'd0, 1'b1}; // SRLI funct7=0000001
    vecs[12] = '{32'h00500090, 3'b000, 5'd0, 5'd5, 5'd0, 1'b1}; // instr[1:0]=00
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h40; in_instr = vecs[0].instr;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
    end
    tick();
    got = {out_valid, out_pc, out_instr, out_imm_sel, out_rs1, out_rs2, out_rd, out_illegal};
    exp = {1'b0, RESET_PC, NOP, 3'b010, 15'd0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_values: got %h expected %h", got, exp);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * i); in_instr = vecs[i].instr;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick();
      got = {out_valid, out_pc, out_instr, out_imm_sel, out_rs1, out_rs2, out_rd, out_illegal};
      exp = {1'b1, 32'h100 + 32'(4 * i), vecs[i].instr, vecs[i].sel, vecs[i].rs1, vecs[i].rs2,
             vecs[i].rd, vecs[i].ill};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL stream_decode[%0d]: got %h expected %h", i, got, exp);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    for (int i = 6; i < 13; i++) begin
      in_valid = 1'b1; in_pc = 32'h180 + 32'(4 * i); in_instr = vecs[i].instr;
      tick();
      got = {out_valid, out_pc, out_instr, out_imm_sel, out_rs1, out_rs2, out_rd, out_illegal};
      exp = {1'b1, 32'h180 + 32'(4 * i), vecs[i].instr, vecs[i].sel, vecs[i].rs1, vecs[i].rs2,
             vecs[i].rd, vecs[i].ill};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL illegal_decode[%0d]: got %h expected %h", i, got, exp);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int next_in = 0;
    int emitted = 0;
    int acc_stall = 0;
    logic held_v = 1'b0;
    logic [63:0] held = '0;
    logic [31:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && emitted < 5; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      in_valid  = (next_in < 5);
      in_pc     = 32'h200 + 32'(4 * next_in);
      in_instr  = (next_in < 5) ? vecs[next_in].instr : 32'h0;
      #1;
      if (out_valid && !out_ready) begin
        if (held_v) begin
          checks++;
          if ({out_pc, out_instr} !== held) begin
            errors++; $display("FAIL stall_hold: got %h expected %h", {out_pc, out_instr}, held);
          end
        end
        held = {out_pc, out_instr}; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_order: got %h expected nothing", out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e) begin
            errors++; $display("FAIL stall_order: got %h expected %h", out_instr, e);
          end
        end
        emitted++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_instr);
        next_in++;
        if (cyc >= 1 && cyc <= 3) acc_stall++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (emitted != 5) begin
      errors++; $display("FAIL stall_emitted: got %0d expected 5", emitted);
    end
    checks++;
    if (acc_stall != EXP_STALL_ACC) begin
      errors++; $display("FAIL stall_accept_count: got %0d expected %0d", acc_stall, EXP_STALL_ACC);
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_leftover: got q=%0d valid=%b expected 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h300; in_instr = vecs[1].instr;
    tick();
    in_pc = 32'h304; in_instr = vecs[2].instr;
    tick();
    flush = 1'b1; in_pc = 32'h308; in_instr = vecs[3].instr;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_cycle: got ready=%b valid=%b expected 0 1", in_ready, out_valid);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got out_valid=%b expected 0", out_valid);
    end
    in_pc = 32'h30C; in_instr = vecs[4].instr;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_resume_ready: got %b expected 1", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h30C, vecs[4].instr}) begin
      errors++; $display("FAIL flush_resume_data: got %h expected %h",
                         {out_valid, out_pc, out_instr}, {1'b1, 32'h30C, vecs[4].instr});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_stale: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h400; in_instr = vecs[0].instr;
    tick();
    in_pc = 32'h404; in_instr = vecs[5].instr;
    tick();
    rst = 1'b1; in_pc = 32'h408; in_instr = vecs[3].instr;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    got = {out_valid, out_pc, out_instr, out_imm_sel, out_rs1, out_rs2, out_rd, out_illegal};
    exp = {1'b0, RESET_PC, NOP, 3'b010, 15'd0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL midreset_values: got %h expected %h", got, exp);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready_after: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_no_emit[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  initial begin
    init_vecs();
    test_reset();
    test_stream();
    test_illegal();
    test_stall();
    test_flush();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_decode.md
# if_id_decode

IF/ID pipeline register with first-level instruction decode, sitting between instruction fetch and the immediate sign-extend unit / register file in the RISC-V core. Accepts one fetched {pc, instruction} per cycle over a valid/ready handshake, registers it, and presents the instruction with its 3-bit immediate-format select code, register specifiers and an illegal-opcode flag. The immediate-format code drives the sign-extend unit's select input directly.

## Interface
- XLEN, 32: PC and instruction width.
- RESET_PC, 32'h0000_0000: value of out_pc after reset.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch has a {pc, instr} pair.
- in_ready  output  1  stage accepts the pair this cycle.
- in_pc  input  XLEN  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- flush  input  1  kill all held instructions (branch/jump redirect).
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  downstream consumes it this cycle.
- out_pc  output  XLEN  registered PC.
- out_instr  output  32  registered instruction; feeds the sign-extend input.
- out_imm_sel  output  3  immediate format code.
- out_rs1, out_rs2, out_rd  output  5 each  register specifiers.
- out_illegal  output  1  opcode not supported.

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Decode from opcode instr[6:0]: 0110111/0010111 (LUI/AUIPC) -> 3'b001; 0000011 (load), 1100111 (JALR) -> 3'b010; 0010011 (OP-IMM) -> 3'b011 when funct3 is 001 or 101, else 3'b010; 1100011 (branch) -> 3'b100; 0100011 (store) -> 3'b101; 1101111 (JAL) -> 3'b110; 0110011, 0001111, 1110011 -> 3'b000.
- out_illegal = 1, imm_sel 3'b000, for any other opcode, for instr[1:0] != 2'b11, for SLLI with funct7 != 0, for SRLI/SRAI with funct7 not 0000000/0100000.
- rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7]; rd forced to 0 for branch, store and illegal instructions.
- Decode happens on the input side; registered fields change only on an input transfer.
- Illegal instructions still pass through with out_valid; trapping is downstream.
- flush: at the next edge, out_valid and any buffered entry cleared; in_ready = 0 during the flush cycle, so no input is accepted. rst beats flush; flush beats a simultaneous transfer.

## Timing
- Latency: input accepted at edge N -> out_valid = 1 after edge N.
- Throughput: one instruction per cycle while out_ready = 1.
- Outputs hold stable while out_valid && !out_ready.
- Reset values: out_valid 0, in_ready 0 while rst high (1 in the first cycle after), out_pc RESET_PC, out_instr 32'h0000_0013 (NOP), out_imm_sel 3'b010, out_rs1/rs2/rd 0, out_illegal 0.
- rst asserted mid-stream drops all held instructions; nothing is emitted.

## Configuration
- ID_SKID_EN defined: a one-entry skid buffer sits behind the output register. in_ready is registered, equal to !skid_valid, with no combinational path from out_ready. A pair accepted while the output is stalled goes to the skid. On the next output transfer the skid moves to the output register with no bubble.
- ID_SKID_EN undefined: no skid buffer. in_ready = !out_valid || out_ready (combinational); the stage holds at most one instruction.

## Structure
- Package rv_decode_pkg: opcode constants; IMM_SEL codes (NONE 000, U 001, I 010, SHAMT 011, B 100, S 101, J 110), shared with the sign-extend unit; NOP constant 32'h0000_0013.
- Sub-module imm_sel_decoder: combinational instr -> {imm_sel, rs1, rs2, rd, illegal}, instantiated once on the input path.

## Test plan
- Stream LUI 0x123450B7, ADDI 0x00500093, SLLI 0x00209113, BEQ 0x00208463, SW 0x0020A023, JAL 0x008000EF with out_ready = 1 -> one per cycle, imm_sel 001, 010, 011, 100, 101, 110, 1-cycle latency, rd = 0 on BEQ/SW.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> outputs stable. With ID_SKID_EN, exactly one extra instruction accepted. Release -> no loss or duplication, order preserved.
- Assert flush with output and skid full and in_valid = 1 -> next cycle out_valid = 0, input not accepted that cycle, fetch resumes the following cycle.
- Instr 0x0000007F, 0x00000000 and SLLI with funct7 = 0100000 -> out_illegal = 1, imm_sel 000, rd 0, out_valid = 1.
- Assert rst for one cycle mid-stream -> out_valid 0, out_pc RESET_PC, out_instr 0x00000013, in_ready 0 during rst, 1 after.
